branch_predictor_unit: RTL and testbench
========================================

Name: branch_predictor_unit

Overview:
Parametrised front-end branch predictor for the 5-stage RV32 pipeline, replacing the separate BTB and BHT pair. It has a tagged BTB, a 2-bit saturating pattern history table (PHT) with a bimodal or gshare index, and a speculative global history register (GHR) with checkpoint restore. It also detects mispredicts at branch resolution in EX and keeps saturating statistics counters. Lookup sits in IF beside the PC register; the update/resolve port is driven from EX.

Parameters:
BTB_IDX_BITS, 6, log2 of BTB entries (64 entries).
TAG_BITS, 8, BTB tag width, taken from PC[BTB_IDX_BITS+TAG_BITS+1 : BTB_IDX_BITS+2].
PHT_IDX_BITS, 8, log2 of PHT entries (256 two-bit counters).
GHR_BITS, 8, global history length; legal range 1..PHT_IDX_BITS.
MODE, 0, 0 = bimodal PHT index, 1 = gshare PHT index.
STAT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fetch_pc  in  32  PC of the instruction being fetched (IF)
fetch_valid  in  1  fetch_pc is a real fetch
stall  in  1  IF stalled; no GHR shift this cycle
pred_taken  out  1  predicted taken
pred_target  out  32  BTB target (0 on miss)
pred_next_pc  out  32  pred_taken ? pred_target : fetch_pc+4
pred_ghr  out  GHR_BITS  GHR value used for this lookup; pipelined to EX with the instruction
update_valid  in  1  a conditional branch or jump resolved in EX this cycle
update_pc  in  32  PC of the resolved instruction
update_taken  in  1  actual direction
update_target  in  32  actual target
update_pred_taken  in  1  prediction carried from IF
update_pred_target  in  32  predicted target carried from IF
update_ghr  in  GHR_BITS  pred_ghr carried from IF
mispredict  out  1  flush and redirect request
redirect_pc  out  32  correct next PC when mispredict=1
branch_count  out  STAT_WIDTH  resolved branches
mispredict_count  out  STAT_WIDTH  mispredicts

Behaviour:
- Reset, asynchronous and active-high:
  - all BTB valid bits = 0;
  - all PHT counters = 2'b01 (weakly not-taken);
  - GHR = 0;
  - both stat counters = 0.
- Lookup is combinational from fetch_pc and current state, with zero latency:
  - bidx = fetch_pc[BTB_IDX_BITS+1:2];
  - hit = valid[bidx] and tag[bidx] matches the fetch_pc tag field;
  - pidx = fetch_pc[PHT_IDX_BITS+1:2], XORed with the zero-extended GHR when MODE=1;
  - pred_taken = hit & pht[pidx][1];
  - pred_ghr = current GHR.
- GHR speculative shift:
  - When fetch_valid & !stall & hit: GHR <= {GHR[GHR_BITS-2:0], pred_taken}. For GHR_BITS=1, GHR <= pred_taken.
  - A miss does not shift.
- Resolve (combinational from the update_* inputs):
  - mispredict = update_valid & ((update_taken != update_pred_taken) | (update_taken & update_target != update_pred_target));
  - redirect_pc = update_taken ? update_target : update_pc+4.
- GHR restore on mispredict: GHR <= {update_ghr[GHR_BITS-2:0], update_taken}. Restore has priority over a same-cycle fetch shift.
- Table update on update_valid, written at the clock edge:
  - PHT entry (indexed from update_pc, XORed with update_ghr when MODE=1) increments if taken, decrements if not, saturating at 3 and 0.
  - If taken, the BTB entry for update_pc is written with valid=1, its tag, and update_target, replacing any previous occupant.
  - Not-taken never allocates or invalidates a BTB entry.
- No read-after-write bypass: a lookup in the same cycle as an update to the same entry sees the old value; the new value is visible next cycle.
- Stats:
  - branch_count += 1 on update_valid;
  - mispredict_count += 1 on mispredict;
  - both saturate at all-ones.
- fetch_valid=0 lookups still drive pred_* outputs, but they have no effect on state.
- PC bits [1:0] are ignored everywhere.

Test Plan:
1. Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0, pred_next_pc=0x104, pred_ghr=0; both counters 0.
2. MODE=0: resolve update_pc=0x100, taken, target 0x80, predicted not-taken -> mispredict=1, redirect_pc=0x80. Next cycle fetch 0x100 -> hit, PHT=2, pred_taken=1, pred_next_pc=0x80.
3. Two more taken updates of 0x100 -> counter saturates at 3. One not-taken update with pred_taken=1 -> mispredict=1, redirect_pc=0x104, counter 2, next lookup still predicts taken.
4. Aliasing: train 0x100 taken, then taken update of 0x100 + (64<<2) -> BTB entry replaced with the new tag; fetch 0x100 -> miss, pred_taken=0.
5. MODE=1, GHR=0xA5: hit fetch shifts GHR to 0x4B (pred_taken=1). The same cycle has a mispredict with update_ghr=0x10, taken -> restore wins, GHR=0x21.
6. Assert rst mid-run after 5 mispredicts -> counters 0 and all BTB entries invalid immediately, without waiting for a clock edge. Same-cycle update+lookup of one entry -> old prediction returned.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// Front-end branch predictor: tagged BTB, 2-bit PHT (bimodal or gshare index),
// speculative GHR with checkpoint restore, mispredict detection and saturating statistics.
module branch_predictor_unit #(
    parameter int BTB_IDX_BITS = 6,
    parameter int TAG_BITS     = 8,
    parameter int PHT_IDX_BITS = 8,
    parameter int GHR_BITS     = 8,
    parameter int MODE         = 0,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           fetch_pc,
    input  logic                  fetch_valid,
    input  logic                  stall,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    output logic [31:0]           pred_next_pc,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic                  update_taken,
    input  logic [31:0]           update_target,
    input  logic                  update_pred_taken,
    input  logic [31:0]           update_pred_target,
    input  logic [GHR_BITS-1:0]   update_ghr,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;
    localparam int TAG_LSB     = BTB_IDX_BITS + 2;
    localparam int TAG_MSB     = BTB_IDX_BITS + TAG_BITS + 1;

    // Only the BTB valid bits and PHT counters need a reset value; tag/target
    // contents are don't-care while their valid bit is clear.
    logic [BTB_ENTRIES-1:0]  btb_valid_q;
    logic [TAG_BITS-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [31:0]             btb_target_q [BTB_ENTRIES];
    logic [1:0]              pht_q        [PHT_ENTRIES];
    logic [GHR_BITS-1:0]     ghr_q, ghr_d;
    logic [STAT_WIDTH-1:0]   branch_count_q, branch_count_d;
    logic [STAT_WIDTH-1:0]   mispredict_count_q, mispredict_count_d;

    logic [BTB_IDX_BITS-1:0] f_bidx, u_bidx;
    logic [TAG_BITS-1:0]     f_tag, u_tag;
    logic [PHT_IDX_BITS-1:0] f_pidx, u_pidx;
    logic [PHT_IDX_BITS-1:0] f_ghr_ext, u_ghr_ext;
    logic                    f_hit;
    logic [1:0]              f_ctr, u_ctr, u_ctr_next;
    logic [GHR_BITS-1:0]     ghr_shift, ghr_restore;
    logic                    unused_pcs;

    assign unused_pcs = ^{fetch_pc, update_pc};

    assign f_bidx    = fetch_pc[BTB_IDX_BITS+1:2];
    assign u_bidx    = update_pc[BTB_IDX_BITS+1:2];
    assign f_tag     = fetch_pc[TAG_MSB:TAG_LSB];
    assign u_tag     = update_pc[TAG_MSB:TAG_LSB];
    assign f_ghr_ext = PHT_IDX_BITS'(ghr_q);
    assign u_ghr_ext = PHT_IDX_BITS'(update_ghr);

    generate
        if (MODE == 1) begin : g_gshare
            assign f_pidx = fetch_pc[PHT_IDX_BITS+1:2] ^ f_ghr_ext;
            assign u_pidx = update_pc[PHT_IDX_BITS+1:2] ^ u_ghr_ext;
        end else begin : g_bimodal
            logic unused_ghr_ext;
            assign unused_ghr_ext = ^{f_ghr_ext, u_ghr_ext};
            assign f_pidx = fetch_pc[PHT_IDX_BITS+1:2];
            assign u_pidx = update_pc[PHT_IDX_BITS+1:2];
        end
    endgenerate

    // Lookup: purely combinational against current state, so a same-cycle
    // update is only visible from the following cycle.
    assign f_hit        = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
    assign f_ctr        = pht_q[f_pidx];
    assign pred_taken   = f_hit & f_ctr[1];
    assign pred_target  = f_hit ? btb_target_q[f_bidx] : 32'd0;
    assign pred_next_pc = pred_taken ? pred_target : fetch_pc + 32'd4;
    assign pred_ghr     = ghr_q;

    assign mispredict  = update_valid &&
                         ((update_taken != update_pred_taken) ||
                          (update_taken && (update_target != update_pred_target)));
    assign redirect_pc = update_taken ? update_target : update_pc + 32'd4;

    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_shift   = pred_taken;
            assign ghr_restore = update_taken;
        end else begin : g_ghrn
            assign ghr_shift   = {ghr_q[GHR_BITS-2:0], pred_taken};
            assign ghr_restore = {update_ghr[GHR_BITS-2:0], update_taken};
        end
    endgenerate

    // A mispredict rewinds history to the checkpoint of the resolving branch,
    // discarding whatever the wrong-path fetch would have shifted in.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = ghr_restore;
        end else if (fetch_valid && !stall && f_hit) begin
            ghr_d = ghr_shift;
        end
    end

    assign u_ctr = pht_q[u_pidx];
    always_comb begin
        u_ctr_next = u_ctr;
        if (update_taken) begin
            if (u_ctr != 2'b11) u_ctr_next = u_ctr + 2'b01;
        end else begin
            if (u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (update_valid) begin
            pht_q[u_pidx] <= u_ctr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid_q <= '0;
        end else if (update_valid && update_taken) begin
            btb_valid_q[u_bidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (update_valid && update_taken) begin
            btb_tag_q[u_bidx]    <= u_tag;
            btb_target_q[u_bidx] <= update_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            ghr_q              <= ghr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench: a bimodal instance (32-bit stats) and a gshare instance
// (3-bit stats, to reach saturation) share one stimulus stream.
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc = 32'h100;
    logic        fetch_valid = 1'b0;
    logic        stall = 1'b0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_pred_taken = 1'b0;
    logic [31:0] update_pred_target = '0;
    logic [7:0]  update_ghr = '0;

    logic        pt0, pt1, mp0, mp1;
    logic [31:0] ptg0, ptg1, pnx0, pnx1, rd0, rd1;
    logic [7:0]  gh0, gh1;
    logic [31:0] bc0, mc0;
    logic [2:0]  bc1, mc1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    branch_predictor_unit #(.MODE(0), .STAT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .stall(stall),
        .pred_taken(pt0), .pred_target(ptg0), .pred_next_pc(pnx0), .pred_ghr(gh0),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target), .update_ghr(update_ghr),
        .mispredict(mp0), .redirect_pc(rd0), .branch_count(bc0), .mispredict_count(mc0)
    );

    branch_predictor_unit #(.MODE(1), .STAT_WIDTH(3)) dut_g (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .stall(stall),
        .pred_taken(pt1), .pred_target(ptg1), .pred_next_pc(pnx1), .pred_ghr(gh1),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target), .update_ghr(update_ghr),
        .mispredict(mp1), .redirect_pc(rd1), .branch_count(bc1), .mispredict_count(mc1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic [7:0] ghr);
        update_valid       = 1'b1;
        update_pc          = pc;
        update_taken       = tk;
        update_target      = tgt;
        update_pred_taken  = ptk;
        update_pred_target = ptgt;
        update_ghr         = ghr;
    endtask

    // Advance through one rising edge; inputs are driven just after the falling edge.
    task automatic step();
        @(negedge clk);
        update_valid = 1'b0;
        fetch_valid  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        rst = 1'b0;
        #1;
        check_val("t1_pred_taken", pt0, 0);
        check_val("t1_pred_target", ptg0, 0);
        check_val("t1_next_pc", pnx0, 32'h104);
        check_val("t1_pred_ghr", gh0, 0);
        check_val("t1_branch_cnt", bc0, 0);
        check_val("t1_misp_cnt", mc0, 0);

        upd(32'h100, 1, 32'h80, 0, 0, 0);
        #1;
        check_val("t2_mispredict", mp0, 1);
        check_val("t2_redirect", rd0, 32'h80);
        step();
        fetch_pc = 32'h100;
        #1;
        check_val("t2_hit_taken", pt0, 1);
        check_val("t2_next_pc", pnx0, 32'h80);
        check_val("t2_branch_cnt", bc0, 1);
        check_val("t2_misp_cnt", mc0, 1);

        upd(32'h100, 1, 32'h80, 1, 32'h80, 0);
        #1;
        check_val("t3_correct_no_misp", mp0, 0);
        step();
        upd(32'h100, 1, 32'h80, 1, 32'h80, 0);
        step();
        upd(32'h100, 0, 32'h80, 1, 32'h80, 0);
        #1;
        check_val("t3_nt_mispredict", mp0, 1);
        check_val("t3_nt_redirect", rd0, 32'h104);
        step();
        #1;
        check_val("t3_ctr2_taken", pt0, 1);
        upd(32'h100, 0, 0, 0, 0, 0);
        step();
        #1;
        check_val("t3_ctr1_not_taken", pt0, 0);
        check_val("t3_nt_keeps_btb", ptg0, 32'h80);

        upd(32'h100, 1, 32'h80, 1, 32'h84, 0);
        #1;
        check_val("t4_target_misp", mp0, 1);
        check_val("t4_target_redirect", rd0, 32'h80);
        step();
        upd(32'h200, 1, 32'h40, 1, 32'h40, 0);
        step();
        fetch_pc = 32'h100;
        #1;
        check_val("t4_alias_miss", pt0, 0);
        check_val("t4_alias_target", ptg0, 0);
        check_val("t4_alias_next", pnx0, 32'h104);
        fetch_pc = 32'h200;
        #1;
        check_val("t4_new_taken", pt0, 1);
        check_val("t4_new_target", ptg0, 32'h40);
        check_val("t4_branch_cnt", bc0, 7);
        check_val("t4_misp_cnt", mc0, 3);

        do_reset();
        upd(32'h200, 1, 32'h300, 1, 32'h300, 8'hA5);
        #1;
        check_val("t5_train_no_misp", mp1, 0);
        step();
        upd(32'h404, 1, 32'h500, 0, 0, 8'h52);
        step();
        fetch_pc = 32'h200;
        #1;
        check_val("t5_ghr_a5", gh1, 32'hA5);
        check_val("t5_gshare_taken", pt1, 1);
        check_val("t5_gshare_target", ptg1, 32'h300);
        fetch_valid = 1'b1;
        step();
        #1;
        check_val("t5_ghr_shift", gh1, 32'h4B);
        upd(32'h404, 1, 32'h500, 0, 0, 8'h52);
        step();
        #1;
        check_val("t5_ghr_restore_a5", gh1, 32'hA5);
        fetch_valid = 1'b1;
        upd(32'h404, 1, 32'h500, 0, 0, 8'h10);
        #1;
        check_val("t5_fetch_hit", pt1, 1);
        check_val("t5_misp", mp1, 1);
        step();
        #1;
        check_val("t5_restore_wins", gh1, 32'h21);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            upd(32'h100, 1, 32'h80, 0, 0, 0);
            step();
        end
        fetch_pc = 32'h100;
        #1;
        check_val("t6_misp_cnt", mc0, 9);
        check_val("t6_branch_cnt", bc0, 9);
        check_val("t6_sat_misp_cnt", mc1, 7);
        check_val("t6_sat_branch_cnt", bc1, 7);
        check_val("t6_pre_rst_hit", pt0, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_async_misp_cnt", mc0, 0);
        check_val("t6_async_branch_cnt", bc0, 0);
        check_val("t6_async_btb_inv", ptg0, 0);
        check_val("t6_async_taken", pt0, 0);
        step();
        rst = 1'b0;
        fetch_pc = 32'h100;
        upd(32'h100, 1, 32'h80, 1, 32'h80, 0);
        #1;
        check_val("t6_raw_old_taken", pt0, 0);
        check_val("t6_raw_old_target", ptg0, 0);
        step();
        #1;
        check_val("t6_new_target", ptg0, 32'h80);
        check_val("t6_new_taken", pt0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
